// File: rtl/pipe_ctl.sv
// Front-end pipeline sequencer: load-use interlock, mul/div and memory holds,
// redirect squashing and a stall-cycle profiling counter.
module pipe_ctl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             mem_busy,
  input  logic             bj_en,
  input  logic             trap_en,
  output logic             if_stall,
  output logic             id_stall,
  output logic             id_clear,
  output logic             ex_stall,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MD_WAIT,
    MEM_WAIT,
    FLUSH
  } state_t;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);

  state_t        state, state_n;
  logic [FW-1:0] flush_cnt, flush_n;
  logic          md_pend, pend_n;
  logic          lu;
  logic          md_go;
  logic          hold;

  assign lu = ex_is_load && (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

  // A launch that completes in the same cycle never needs a hold.
  assign md_go = md_start && !md_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
      md_pend   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_n;
      md_pend   <= pend_n;
      if (if_stall)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    flush_n = flush_cnt;
    pend_n  = md_pend;
    if (trap_en) begin
      pend_n = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_n = FLUSH;
        flush_n = FLUSH_INIT;
      end else begin
        state_n = RUN;
      end
    end else if (!bj_en) begin
      unique case (state)
        RUN: begin
          pend_n = 1'b0;
          if (mem_busy) begin
            state_n = MEM_WAIT;
            pend_n  = md_go;
          end else if (md_go) begin
            state_n = MD_WAIT;
          end
        end
        MD_WAIT: begin
          if (md_done)
            state_n = RUN;
        end
        MEM_WAIT: begin
          pend_n = md_pend && !md_done;
          if (!mem_busy) begin
            state_n = (md_pend && !md_done) ? MD_WAIT : RUN;
            pend_n  = 1'b0;
          end
        end
        FLUSH: begin
          if (flush_cnt <= FW'(1))
            state_n = RUN;
          else
            flush_n = flush_cnt - FW'(1);
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_comb begin
    if_stall = 1'b0;
    id_stall = 1'b0;
    id_clear = 1'b0;
    ex_stall = 1'b0;
    hold     = 1'b0;
    if (!rst_n) begin
      hold = 1'b0;
    end else if (trap_en || bj_en) begin
      id_clear = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy || md_go) begin
            hold = 1'b1;
          end else if (lu) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            id_clear = 1'b1;
          end
        end
        MD_WAIT:  hold = !md_done;
        MEM_WAIT: hold = mem_busy;
        FLUSH:    id_clear = 1'b1;
        default:  hold = 1'b0;
      endcase
      if (hold) begin
        if_stall = 1'b1;
        id_stall = 1'b1;
        ex_stall = 1'b1;
      end
    end
  end

  assign busy = (state != RUN);

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl: hazards, holds, redirects, reset and
// counter wrap on a narrow-counter instance.
module tb_pipe_ctl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load;
  logic        md_start, md_done, mem_busy, bj_en, trap_en;
  logic        if_stall, id_stall, id_clear, ex_stall, busy;
  logic [31:0] stall_cnt;
  logic        if_stall4, id_stall4, id_clear4, ex_stall4, busy4;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  pipe_ctl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .md_start(md_start), .md_done(md_done),
    .mem_busy(mem_busy), .bj_en(bj_en), .trap_en(trap_en),
    .if_stall(if_stall), .id_stall(id_stall),
    .id_clear(id_clear), .ex_stall(ex_stall),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  pipe_ctl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .md_start(md_start), .md_done(md_done),
    .mem_busy(mem_busy), .bj_en(bj_en), .trap_en(trap_en),
    .if_stall(if_stall4), .id_stall(id_stall4),
    .id_clear(id_clear4), .ex_stall(ex_stall4),
    .busy(busy4), .stall_cnt(stall_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_is_load = 0;
    md_start = 0; md_done = 0; mem_busy = 0;
    bj_en = 0; trap_en = 0;
  endtask

  task automatic set_lu();
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  task automatic chk_out(input string tag, input logic i_s,
                         input logic d_s, input logic clr,
                         input logic e_s, input logic b);
    chk({tag, ".if_stall"}, {31'b0, if_stall}, {31'b0, i_s});
    chk({tag, ".id_stall"}, {31'b0, id_stall}, {31'b0, d_s});
    chk({tag, ".id_clear"}, {31'b0, id_clear}, {31'b0, clr});
    chk({tag, ".ex_stall"}, {31'b0, ex_stall}, {31'b0, e_s});
    chk({tag, ".busy"}, {31'b0, busy}, {31'b0, b});
  endtask

  initial begin
    idle();
    rst_n = 0;
    #3;
    chk_out("rst", 0, 0, 0, 0, 0);
    chk("rst.cnt", stall_cnt, 0);
    cyc(); cyc();
    rst_n = 1;
    #3;
    chk_out("post_rst", 0, 0, 0, 0, 0);
    chk("post_rst.cnt", stall_cnt, 0);

    cyc(); set_lu(); #3;
    chk_out("lu", 1, 1, 1, 0, 0);
    cyc(); idle(); #3;
    chk_out("lu_after", 0, 0, 0, 0, 0);
    chk("lu.cnt", stall_cnt, 1);

    cyc(); ex_is_load = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; #3;
    chk_out("x0_load", 0, 0, 0, 0, 0);

    cyc(); idle(); id_rs2 = 9; ex_rd = 9; ex_is_load = 1; #3;
    chk_out("rs2_unused", 0, 0, 0, 0, 0);

    cyc(); idle(); md_start = 1; #3;
    chk_out("md_start", 1, 1, 0, 1, 0);
    for (int i = 1; i < 4; i++) begin
      cyc(); idle(); #3;
      chk_out("md_wait", 1, 1, 0, 1, 1);
    end
    cyc(); md_done = 1; #3;
    chk_out("md_done", 0, 0, 0, 0, 1);
    cyc(); idle(); #3;
    chk_out("md_run", 0, 0, 0, 0, 0);
    chk("md.cnt", stall_cnt, 5);

    cyc(); md_start = 1; md_done = 1; #3;
    chk_out("md_same", 0, 0, 0, 0, 0);
    cyc(); idle(); #3;
    chk_out("md_same_after", 0, 0, 0, 0, 0);

    cyc(); md_start = 1; #3;
    cyc(); idle(); #3;
    chk_out("trap_pre", 1, 1, 0, 1, 1);
    cyc(); trap_en = 1; #3;
    chk_out("trap", 0, 0, 1, 0, 1);
    cyc(); idle(); #3;
    chk_out("flush", 0, 0, 1, 0, 1);
    cyc(); #3;
    chk_out("flush_done", 0, 0, 0, 0, 0);
    chk("trap.cnt", stall_cnt, 7);

    cyc(); set_lu(); bj_en = 1; #3;
    chk_out("bj_lu", 0, 0, 1, 0, 0);
    cyc(); idle(); #3;
    chk_out("bj_after", 0, 0, 0, 0, 0);
    chk("bj.cnt", stall_cnt, 7);

    cyc(); mem_busy = 1; md_start = 1; #3;
    chk_out("mem_md", 1, 1, 0, 1, 0);
    cyc(); idle(); mem_busy = 1; #3;
    chk_out("mem_wait", 1, 1, 0, 1, 1);
    cyc(); idle(); #3;
    chk_out("mem_exit", 0, 0, 0, 0, 1);
    cyc(); #3;
    chk_out("pend_md", 1, 1, 0, 1, 1);
    cyc(); md_done = 1; #3;
    chk_out("pend_done", 0, 0, 0, 0, 1);
    cyc(); idle(); #3;
    chk_out("pend_run", 0, 0, 0, 0, 0);
    chk("pend.cnt", stall_cnt, 10);

    cyc(); mem_busy = 1;
    cyc(); #3;
    chk_out("mem2", 1, 1, 0, 1, 1);
    chk("mem2.cnt", stall_cnt, 11);
    #1 rst_n = 0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst.cnt", stall_cnt, 0);
    chk("async_rst.cnt4", {28'b0, stall_cnt4}, 0);
    idle();
    cyc(); cyc();
    rst_n = 1;

    mem_busy = 1;
    repeat (15) cyc();
    #3;
    chk("wrap15.cnt4", {28'b0, stall_cnt4}, 15);
    cyc(); idle(); #3;
    chk("wrap.cnt4", {28'b0, stall_cnt4}, 0);
    chk("wrap.cnt", stall_cnt, 16);
    chk_out("wrap_exit", 0, 0, 0, 0, 1);
    cyc(); #3;
    chk_out("wrap_run", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
